ksa_multiword_seq: RTL
======================

Name: ksa_multiword_seq

Overview:
Sequencer that performs NWORDS×32-bit add/subtract by time-multiplexing one instance of the team's 32-bit Kogge-Stone adder (KSA), one word per cycle, least significant word first. Carry is chained through a register between words. Upstream and downstream use valid/ready handshakes. Used wherever a wide add is needed but a full-width prefix tree is too costly in area.

Parameters:
NWORDS, 4, number of 32-bit words per operand; legal range 1..16.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous assert, active-low
start_valid  input  1  operand request valid
start_ready  output  1  sequencer can accept a request (high only in IDLE)
op_a  input  NWORDS*32  operand A; word k occupies bits [32k+31:32k]
op_b  input  NWORDS*32  operand B
sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1, cin ignored)
cin  input  1  carry-in for add
flush  input  1  synchronous abort of an in-flight operation
res_valid  output  1  result valid
res_ready  input  1  downstream accepts result
result  output  NWORDS*32  sum/difference
carry_out  output  1  carry out of MSW (for sub: 1 = no borrow, A>=B unsigned)
overflow  output  1  signed two's-complement overflow of the full-width operation
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, any state, mid-operation included): state IDLE; result, carry_out, overflow, res_valid, busy, word index, carry reg and operand regs all 0. start_ready=1 while in IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid & start_ready at edge: capture op_a, op_b, sub; carry reg <= sub ? 1 : cin; index <= 0; clear result; go RUN. flush in IDLE has no effect.
- RUN: adder inputs a = A word[index], b = B word[index] XOR {32{sub}}, cin = carry reg. Each edge: result word[index] <= adder sum; carry reg <= adder cout; index <= index+1. On edge with index == NWORDS-1: carry_out <= adder cout; overflow <= (a[31] == b[31]) & (sum[31] != a[31]) using the inverted b word; go DONE.
- Latency: RUN lasts exactly NWORDS cycles; res_valid rises NWORDS edges after the acceptance edge (NWORDS=1: one edge).
- flush high in RUN: next edge go IDLE; result, carry_out, overflow cleared; no res_valid pulse. flush takes priority over completion on the final RUN edge.
- DONE: res_valid=1; result, carry_out, overflow held stable until res_valid & res_ready at an edge, then go IDLE (res_valid drops, outputs retain their values until the next acceptance). flush in DONE is ignored.
- start_valid outside IDLE is ignored; requester must hold its request until accepted. Earliest next acceptance is the edge after the result handshake (one IDLE cycle minimum between operations).
- Operands are sampled only at acceptance; later changes on op_a/op_b/sub/cin do not affect the operation in flight.
- Index counter width = clog2(NWORDS) bits, minimum 1; it never wraps past NWORDS-1.
- busy = (state != IDLE).

Test Plan:
1. NWORDS=4, add, A=0x00000000_00000000_00000000_FFFFFFFF, B=1, cin=0 -> result=0x00000000_00000000_00000001_00000000, carry_out=0, overflow=0, res_valid exactly 4 edges after acceptance.
2. Full ripple: A=all-ones (128 bits), B=0, cin=1 -> result=0, carry_out=1, overflow=0.
3. Subtract: A=5, B=7, sub=1 -> result=0xFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, carry_out=0 (borrow), overflow=0. Then A=7, B=5 -> result=2, carry_out=1.
4. Signed overflow: A=0x7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1, add -> result=0x80000000_00000000_00000000_00000000, overflow=1, carry_out=0.
5. Backpressure: hold res_ready=0 for 10 cycles in DONE while pulsing start_valid with new operands -> result/flags stable, start_ready=0, no new operation. Then release -> IDLE, then next request accepted one cycle later and computed correctly.
6. Abort: assert rst_n=0 asynchronously at RUN index 2 -> all outputs 0 immediately, start_ready=1. Repeat with flush at index 2 -> IDLE next edge, no res_valid, result=0.

Source files
------------

// File: rtl/ksa_multiword_seq.sv
// Multi-word add/subtract sequencer: one 32-bit Kogge-Stone adder reused once per word,
// least significant word first, with the carry chained through a register.
`timescale 1ns/1ps
module ksa_multiword_seq #(
  parameter int NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [NWORDS*32-1:0]   op_a,
  input  logic [NWORDS*32-1:0]   op_b,
  input  logic                   sub,
  input  logic                   cin,
  input  logic                   flush,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [NWORDS*32-1:0]   result,
  output logic                   carry_out,
  output logic                   overflow,
  output logic                   busy
);

  localparam int W  = NWORDS * 32;
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [IW-1:0] idx;
  logic          carry_r;
  logic          sub_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [31:0]   a_w;
  logic [31:0]   b_w;
  logic [31:0]   sum_w;
  logic          cout_w;

  // Kogge-Stone prefix adder; the carry-in is folded into bit 0's generate so the
  // prefix tree directly yields every carry including the one out of bit 31.
  function automatic logic [32:0] ksa32(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci);
    logic [31:0] g, p, gn, pn;
    g    = a & b;
    p    = a ^ b;
    g[0] = g[0] | (p[0] & ci);
    for (int d = 1; d < 32; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < 32; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    ksa32 = {g[31], (a ^ b) ^ {g[30:0], ci}};
  endfunction

  assign a_w = a_r[{idx, 5'b0} +: 32];
  assign b_w = b_r[{idx, 5'b0} +: 32] ^ {32{sub_r}};
  assign {cout_w, sum_w} = ksa32(a_w, b_w, carry_r);

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid) state_nxt = RUN;
      RUN:     if (flush) state_nxt = IDLE;
               else if (idx == LAST) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      carry_r   <= 1'b0;
      sub_r     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_r     <= op_a;
            b_r     <= op_b;
            sub_r   <= sub;
            carry_r <= sub | cin;
            idx     <= '0;
            result  <= '0;
          end
        end
        RUN: begin
          // Abort wins over completion so a flushed operation never reaches DONE.
          if (flush) begin
            idx       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
          end else begin
            result[{idx, 5'b0} +: 32] <= sum_w;
            carry_r                   <= cout_w;
            if (idx == LAST) begin
              carry_out <= cout_w;
              overflow  <= (a_w[31] == b_w[31]) & (sum_w[31] != a_w[31]);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
